freq_meter: RTL and testbench

//  Measures the frequency of an asynchronous input (e.g. a divided clock) by counting its

---
 rtl/freq_meter_if.sv | 21 ++
 rtl/freq_meter.sv | 125 ++++++++++++
 tb/tb_freq_meter.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/freq_meter_if.sv
// Measurement bus of freq_meter: signal under test, start request and the result/status outputs.
interface freq_meter_if #(
   parameter int CNT_W = 32
);
   logic             sig_in;
   logic             start;
   logic             busy;
   logic             valid;
   logic             ovf;
   logic [CNT_W-1:0] freq_out;

   modport master (
      output sig_in, start,
      input  busy, valid, ovf, freq_out
   );

   modport slave (
      input  sig_in, start,
      output busy, valid, ovf, freq_out
   );
endinterface

// File: rtl/freq_meter.sv
// Counts rising edges of an asynchronous sig_in over a window of GATE_CYCLES in_clk cycles.
// Define FREQ_METER_CONTINUOUS_EN for back-to-back windows without start requests.
module freq_meter #(
   parameter int GATE_CYCLES = 100000000,
   parameter int CNT_W       = 32,
   parameter int SYNC_STAGES = 2
) (
   input logic          in_clk,
   input logic          rst_n,
   freq_meter_if.slave  bus
);
   localparam int              GW        = $clog2(GATE_CYCLES + 1);
   localparam logic [GW-1:0]   GATE_LAST = GW'(GATE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   typedef enum logic [1:0] {IDLE, MEASURE, DONE} state_t;

   state_t                 state_reg;
   logic [SYNC_STAGES-1:0] sync_reg;
   logic                   hist_reg;
   logic [GW-1:0]          gate_cnt_reg;
   logic [CNT_W-1:0]       edge_cnt_reg;
   logic                   sat_reg;
   logic                   busy_reg;
   logic                   valid_reg;
   logic                   ovf_reg;
   logic [CNT_W-1:0]       freq_reg;

   logic                   edge_pulse;
   logic                   launch;
   logic [CNT_W-1:0]       cnt_next;
   logic                   sat_next;

   always_ff @(posedge in_clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_reg <= '0;
         hist_reg <= 1'b0;
      end else begin
         sync_reg <= {sync_reg[SYNC_STAGES-2:0], bus.sig_in};
         hist_reg <= sync_reg[SYNC_STAGES-1];
      end
   end

   assign edge_pulse = sync_reg[SYNC_STAGES-1] & ~hist_reg;

`ifdef FREQ_METER_CONTINUOUS_EN
   assign launch = 1'b1;
`else
   assign launch = bus.start;
`endif

   // Count including the current cycle's edge, so the last window cycle is not lost.
   always_comb begin
      cnt_next = edge_cnt_reg;
      sat_next = sat_reg;
      if (edge_pulse) begin
         if (edge_cnt_reg == CNT_MAX) begin
            sat_next = 1'b1;
         end else begin
            cnt_next = edge_cnt_reg + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge in_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg    <= IDLE;
         gate_cnt_reg <= '0;
         edge_cnt_reg <= '0;
         sat_reg      <= 1'b0;
         busy_reg     <= 1'b0;
         valid_reg    <= 1'b0;
         ovf_reg      <= 1'b0;
         freq_reg     <= '0;
      end else begin
         valid_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (launch) begin
                  state_reg    <= MEASURE;
                  busy_reg     <= 1'b1;
                  gate_cnt_reg <= '0;
                  edge_cnt_reg <= '0;
                  sat_reg      <= 1'b0;
               end
            end
            MEASURE: begin
               if (gate_cnt_reg == GATE_LAST) begin
                  freq_reg  <= cnt_next;
                  ovf_reg   <= sat_next;
                  valid_reg <= 1'b1;
`ifdef FREQ_METER_CONTINUOUS_EN
                  // Roll straight into the next window; result shows in its first cycle.
                  gate_cnt_reg <= '0;
                  edge_cnt_reg <= '0;
                  sat_reg      <= 1'b0;
`else
                  state_reg    <= DONE;
                  busy_reg     <= 1'b0;
                  gate_cnt_reg <= gate_cnt_reg + GW'(1);
                  edge_cnt_reg <= cnt_next;
                  sat_reg      <= sat_next;
`endif
               end else begin
                  gate_cnt_reg <= gate_cnt_reg + GW'(1);
                  edge_cnt_reg <= cnt_next;
                  sat_reg      <= sat_next;
               end
            end
            DONE: begin
               state_reg <= IDLE;
            end
            default: begin
               state_reg <= IDLE;
               busy_reg  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.busy     = busy_reg;
   assign bus.valid    = valid_reg;
   assign bus.ovf      = ovf_reg;
   assign bus.freq_out = freq_reg;
endmodule

// File: tb/tb_freq_meter.sv
// Scoreboard bench for freq_meter: dut_a (GATE 20, 8-bit) and dut_b (GATE 40, 4-bit).
// Define FREQ_METER_CONTINUOUS_EN to exercise the back-to-back window build.
module tb_freq_meter;
   typedef struct packed {
      logic [31:0] freq;
      logic        ovf;
      logic        skip;
   } exp_t;

   logic clk;
   logic rst_n;
   logic rst_b_n;

   int checks   = 0;
   int failures = 0;

   exp_t exp_a[$];
   exp_t exp_b[$];

   int   mode_a, mode_b;
   logic lvl_a, lvl_b;

   freq_meter_if #(.CNT_W(8)) bus_a ();
   freq_meter_if #(.CNT_W(4)) bus_b ();

   freq_meter #(.GATE_CYCLES(20), .CNT_W(8), .SYNC_STAGES(2)) dut_a (
      .in_clk (clk),
      .rst_n  (rst_n),
      .bus    (bus_a.slave)
   );

   freq_meter #(.GATE_CYCLES(40), .CNT_W(4), .SYNC_STAGES(2)) dut_b (
      .in_clk (clk),
      .rst_n  (rst_b_n),
      .bus    (bus_b.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end else begin
         $display("ok   %s: %0d", name, act);
      end
   endtask

   // sig_in generators: mode 0 static level, 1 = 2 high / 2 low, 2 = toggle every cycle
   initial begin
      int ph;
      ph = 0;
      bus_a.sig_in = 1'b0;
      forever begin
         @(negedge clk);
         ph++;
         case (mode_a)
            1:       bus_a.sig_in = ((ph % 4) >= 2);
            2:       bus_a.sig_in = ph[0];
            default: bus_a.sig_in = lvl_a;
         endcase
      end
   end

   initial begin
      int ph;
      ph = 0;
      bus_b.sig_in = 1'b0;
      forever begin
         @(negedge clk);
         ph++;
         case (mode_b)
            1:       bus_b.sig_in = ((ph % 4) >= 2);
            2:       bus_b.sig_in = ph[0];
            default: bus_b.sig_in = lvl_b;
         endcase
      end
   end

   // Monitors: pop the scoreboard on every valid pulse
   initial begin
      logic prev;
      exp_t e;
      prev = 1'b0;
      forever begin
         @(negedge clk);
         if (rst_n && bus_a.valid) begin
            chk("a_valid_not_back_to_back", prev, 0);
            if (exp_a.size() == 0) begin
               chk("a_unexpected_valid_freq", bus_a.freq_out, -1);
            end else begin
               e = exp_a.pop_front();
               if (!e.skip) begin
                  chk("a_freq_out", bus_a.freq_out, e.freq);
                  chk("a_ovf", bus_a.ovf, e.ovf);
               end
            end
         end
         prev = bus_a.valid;
      end
   end

   initial begin
      logic prev;
      exp_t e;
      prev = 1'b0;
      forever begin
         @(negedge clk);
         if (rst_b_n && bus_b.valid) begin
            chk("b_valid_not_back_to_back", prev, 0);
            if (exp_b.size() == 0) begin
               chk("b_unexpected_valid_freq", bus_b.freq_out, -1);
            end else begin
               e = exp_b.pop_front();
               if (!e.skip) begin
                  chk("b_freq_out", bus_b.freq_out, e.freq);
                  chk("b_ovf", bus_b.ovf, e.ovf);
               end
            end
         end
         prev = bus_b.valid;
      end
   end

   // Start at cycle 0, watch cycles 1..span; extra start pulses in cycles r1/r2/r3
   task automatic run(input int sel, input int span, input int r1, input int r2, input int r3,
                      output int busy_n, output int valid_at, output int valid_n,
                      output int early_chg);
      longint prev_f, f;
      logic   b, v, s;
      busy_n = 0; valid_at = -1; valid_n = 0; early_chg = 0;
      prev_f = (sel == 0) ? longint'(bus_a.freq_out) : longint'(bus_b.freq_out);
      if (sel == 0) bus_a.start = 1'b1; else bus_b.start = 1'b1;
      @(negedge clk);
      for (int c = 1; c <= span; c++) begin
         if (sel == 0) begin
            b = bus_a.busy; v = bus_a.valid; f = bus_a.freq_out;
         end else begin
            b = bus_b.busy; v = bus_b.valid; f = bus_b.freq_out;
         end
         if (b) busy_n++;
         if (v) begin
            valid_n++;
            if (valid_at < 0) valid_at = c;
         end else if (valid_at < 0 && f != prev_f) begin
            early_chg++;
         end
         s = (c == r1) || (c == r2) || (c == r3);
         if (sel == 0) bus_a.start = s; else bus_b.start = s;
         @(negedge clk);
      end
      bus_a.start = 1'b0;
      bus_b.start = 1'b0;
   endtask

   initial begin
      int busy_n, valid_at, valid_n, early;
      rst_n = 1'b0; rst_b_n = 1'b0;
      bus_a.start = 1'b0; bus_b.start = 1'b0;
      mode_a = 0; mode_b = 0; lvl_a = 1'b0; lvl_b = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_busy", bus_a.busy, 0);
      chk("reset_valid", bus_a.valid, 0);
      chk("reset_ovf", bus_a.ovf, 0);
      chk("reset_freq_out", bus_a.freq_out, 0);
`ifdef FREQ_METER_CONTINUOUS_EN
      begin
         int nval, last, sum;
         mode_a = 1;
         repeat (6) @(negedge clk);
         exp_a.push_back('{freq: 32'd0, ovf: 1'b0, skip: 1'b1});
         repeat (5) exp_a.push_back('{freq: 32'd5, ovf: 1'b0, skip: 1'b0});
         rst_n = 1'b1;
         nval = 0; last = 0; sum = 0;
         for (int c = 1; c <= 300 && nval < 6; c++) begin
            @(negedge clk);
            if (bus_a.valid) begin
               if (nval > 0) begin
                  chk("cont_valid_period", c - last, 20);
                  sum += int'(bus_a.freq_out);
               end
               last = c;
               nval++;
            end
         end
         chk("cont_valid_count", nval, 6);
         chk("cont_edge_sum_5_windows", sum, 25);
         chk("cont_busy", bus_a.busy, 1);
      end
`else
      chk("b_reset_freq_out", bus_b.freq_out, 0);
      rst_n = 1'b1; rst_b_n = 1'b1;

      // 4-cycle sig_in -> 5 edges in 20 cycles
      mode_a = 1;
      repeat (10) @(negedge clk);
      exp_a.push_back('{freq: 32'd5, ovf: 1'b0, skip: 1'b0});
      run(0, 30, -1, -1, -1, busy_n, valid_at, valid_n, early);
      chk("t1_busy_cycles", busy_n, 20);
      chk("t1_valid_cycle", valid_at, 21);
      chk("t1_valid_count", valid_n, 1);

      // static high -> 0 edges
      mode_a = 0; lvl_a = 1'b1;
      repeat (5) @(negedge clk);
      exp_a.push_back('{freq: 32'd0, ovf: 1'b0, skip: 1'b0});
      run(0, 30, -1, -1, -1, busy_n, valid_at, valid_n, early);
      chk("t2_valid_cycle", valid_at, 21);
      chk("t2_busy_cycles", busy_n, 20);

      // toggle every cycle: 10 edges in 20 cycles, 20 edges saturate a 4-bit counter
      mode_a = 2;
      repeat (5) @(negedge clk);
      exp_a.push_back('{freq: 32'd10, ovf: 1'b0, skip: 1'b0});
      run(0, 30, -1, -1, -1, busy_n, valid_at, valid_n, early);
      chk("t3a_valid_count", valid_n, 1);

      mode_b = 2;
      repeat (5) @(negedge clk);
      exp_b.push_back('{freq: 32'd15, ovf: 1'b1, skip: 1'b0});
      run(1, 50, -1, -1, -1, busy_n, valid_at, valid_n, early);
      chk("t3b_busy_cycles", busy_n, 40);
      chk("t3b_valid_cycle", valid_at, 41);

      mode_b = 0; lvl_b = 1'b0;
      repeat (5) @(negedge clk);
      exp_b.push_back('{freq: 32'd0, ovf: 1'b0, skip: 1'b0});
      run(1, 50, -1, -1, -1, busy_n, valid_at, valid_n, early);
      chk("t3c_valid_count", valid_n, 1);

      // start re-pulsed in window cycles 5 and 20 and in the DONE cycle
      mode_a = 1;
      repeat (10) @(negedge clk);
      exp_a.push_back('{freq: 32'd5, ovf: 1'b0, skip: 1'b0});
      run(0, 30, 5, 20, 21, busy_n, valid_at, valid_n, early);
      chk("t4_valid_count", valid_n, 1);
      chk("t4_busy_cycles", busy_n, 20);
      chk("t4_freq_held_until_done", early, 0);
      exp_a.push_back('{freq: 32'd5, ovf: 1'b0, skip: 1'b0});
      run(0, 30, -1, -1, -1, busy_n, valid_at, valid_n, early);
      chk("t4_restart_valid_count", valid_n, 1);

      // reset in window cycle 10
      bus_a.start = 1'b1;
      @(negedge clk);
      bus_a.start = 1'b0;
      repeat (9) @(negedge clk);
      chk("t5_busy_before_reset", bus_a.busy, 1);
      rst_n = 1'b0;
      #1;
      chk("t5_busy_after_reset", bus_a.busy, 0);
      chk("t5_freq_after_reset", bus_a.freq_out, 0);
      chk("t5_ovf_after_reset", bus_a.ovf, 0);
      @(negedge clk);
      rst_n = 1'b1;
      valid_n = 0; busy_n = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (bus_a.valid) valid_n++;
         if (bus_a.busy) busy_n++;
      end
      chk("t5_no_valid_after_release", valid_n, 0);
      chk("t5_no_busy_after_release", busy_n, 0);
      chk("b_queue_empty", exp_b.size(), 0);
`endif
      chk("a_queue_empty", exp_a.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
